axis_pkt_rr_arbiter: RTL and testbench
======================================

Name: axis_pkt_rr_arbiter

Overview:
Packet-level round-robin arbiter that shares one byte-wide AXI4-Stream datapath, the 1-to-4 byte width converter input, between NUM_SRC byte-wide stream sources. A grant is held from the first beat of a packet through its tlast beat, so packets are never interleaved at the converter. The output is fully registered through a 2-entry skid buffer and tagged with the source index.

Parameters:
NUM_SRC, 4, number of requesting slave streams (2..8)
DATA_WIDTH, 8, tdata width per stream in bits (multiple of 8)
CNT_WIDTH, 16, width of the completed-packet counter

Ports:
aclk  in  1  clock, rising edge
areset  in  1  asynchronous reset, active-high
s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data; source i occupies slice i
s_axis_tkeep  in  NUM_SRC*DATA_WIDTH/8  source byte enables
s_axis_tlast  in  NUM_SRC  source end-of-packet
s_axis_tvalid  in  NUM_SRC  source valid
s_axis_tready  out  NUM_SRC  source ready; at most one bit high
m_axis_tdata  out  DATA_WIDTH  muxed data to the width converter
m_axis_tkeep  out  DATA_WIDTH/8  muxed byte enables
m_axis_tlast  out  1  muxed end-of-packet
m_axis_tid  out  clog2(NUM_SRC)  index of the source that produced the beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
grant_idx  out  clog2(NUM_SRC)  currently or last granted source
busy  out  1  high while in XFER
pkt_count  out  CNT_WIDTH  number of tlast beats accepted from sources; wraps

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=NUM_SRC-1, skid buffer empty. Outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tid=0, grant_idx=NUM_SRC-1, busy=0, pkt_count=0. Reset mid-packet drops the in-flight and buffered beats. The downstream sees tvalid fall immediately, with no tlast.
- FSM IDLE: if any s_axis_tvalid is high, choose the first valid source scanning from (last_grant+1) mod NUM_SRC upward with wrap. Register grant_idx and last_grant to that source, and go to XFER. If no source is valid, stay in IDLE. Arbitration looks at tvalid only, never at data.
- FSM XFER: s_axis_tready[grant_idx] = !skid_full. All other tready bits are 0. A beat is accepted when tvalid&tready on the granted source. Accepting a beat with tlast=1: pkt_count increments and the state goes to IDLE on the next edge, so tready drops the cycle after the tlast beat.
- A source dropping tvalid mid-packet holds the grant; the arbiter waits indefinitely. No timeout.
- Output buffer: 2 entries, main register and skid register, each holding {tdata, tkeep, tlast, tid}.
  - An accepted beat appears on m_axis exactly 1 cycle later when the main register is empty or draining.
  - Order is preserved.
  - m_axis_* is stable while tvalid=1 and tready=0.
  - skid_full means both entries are occupied; it is the only path that stalls the source.
  - All m_axis outputs come straight from registers. There is no combinational path from s_axis to m_axis.
  - tready to the source is a function of state and registers only.
- Throughput: 1 beat/cycle within a packet. Exactly 1 idle arbitration cycle between packets, on the source side only. The output may still be draining the previous packet while the next grant is issued.
- Simultaneous events:
  - A tlast accept and a new tvalid on another source in the same cycle: the new source is not granted until the IDLE cycle that follows.
  - The same source with back-to-back packets is re-granted only if no other source is valid; round-robin guarantees fairness.
- pkt_count wraps from 2^CNT_WIDTH-1 to 0.
- tkeep is passed through unmodified; a tkeep=0 beat is forwarded as-is.

Test Plan:
- Reset release; source 0 sends 8 beats, data 0..7, tlast on beats 4 and 7; no backpressure -> m_axis shows 0..7 with tid=0, tlast on data 4 and 7, and 1 idle cycle between the packets; pkt_count=2.
- Sources 0, 1 and 3 each hold a 3-beat packet valid at the same time (data 0xA0.., 0xB0.., 0xD0..) -> output order is src0, src1, src3; packets are not interleaved; tid matches each packet; grant_idx=3 at the end.
- Source 2 sends 4 beats while m_axis_tready is held low 5 cycles after the first beat -> s_axis_tready[2] falls after 2 beats are buffered; all 4 beats arrive in order once tready rises; m_axis_tdata holds stable while stalled.
- Source 1 drops tvalid for 3 cycles mid-packet while source 0 is valid -> grant stays on 1, source 0 sees tready=0, source 0 is granted only after source 1's tlast.
- areset pulses high mid-packet with 2 beats buffered -> m_axis_tvalid and all s_axis_tready go to 0 immediately, pkt_count=0; after release, source 0 wins the first arbitration.
- With CNT_WIDTH=4, send 17 single-beat packets -> pkt_count reads 1.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI4-Stream sources share one
// output stream. A grant is held from the first beat of a packet through its
// tlast beat, so packets are never interleaved downstream. Output beats are
// fully registered through a two-entry (main + skid) buffer and tagged with
// the index of the source that produced them.
module axis_pkt_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int KEEP_W    = DATA_WIDTH / 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]     s_axis_tkeep,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]             m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [IDX_W-1:0]              m_axis_tid,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  // grant_reg doubles as the last-granted pointer for round-robin scanning.
  logic [IDX_W-1:0]       grant_reg, grant_next;
  logic [CNT_WIDTH-1:0]   pkt_count_reg;

  // Output buffer: main register drives m_axis, skid register catches the
  // beat accepted while the main register is full and not draining.
  logic                   main_valid_reg;
  logic [DATA_WIDTH-1:0]  main_data_reg;
  logic [KEEP_W-1:0]      main_keep_reg;
  logic                   main_last_reg;
  logic [IDX_W-1:0]       main_tid_reg;
  logic                   skid_valid_reg;
  logic [DATA_WIDTH-1:0]  skid_data_reg;
  logic [KEEP_W-1:0]      skid_keep_reg;
  logic                   skid_last_reg;
  logic [IDX_W-1:0]       skid_tid_reg;

  logic                   skid_full;
  logic [NUM_SRC-1:0]     ready_vec;
  logic                   accept;

  // Per-source views of the flattened input buses.
  logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];
  logic [KEEP_W-1:0]      src_keep [NUM_SRC];

  logic [DATA_WIDTH-1:0]  sel_data;
  logic [KEEP_W-1:0]      sel_keep;
  logic                   sel_last;

  logic                   found;
  int                     scan_idx;

  // Both entries occupied is the only condition that stalls the source.
  assign skid_full = main_valid_reg & skid_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi]  = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_keep[gi]  = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
      // Ready depends only on registered state, never on s_axis inputs.
      assign ready_vec[gi] = (state_reg == XFER) &&
                             (grant_reg == IDX_W'(gi)) && !skid_full;
    end
  endgenerate

  assign s_axis_tready = ready_vec;
  assign accept        = |(s_axis_tvalid & ready_vec);

  assign sel_data = src_data[grant_reg];
  assign sel_keep = src_keep[grant_reg];
  assign sel_last = s_axis_tlast[grant_reg];

  // State and grant registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg <= IDLE;
      grant_reg <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  // Next-state logic: round-robin scan in IDLE, hold grant until tlast in XFER.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    found      = 1'b0;
    scan_idx   = 0;
    case (state_reg)
      IDLE: begin
        // Scan starts one past the last grant and wraps, so the last winner
        // is considered only after every other source.
        for (int k = 1; k <= NUM_SRC; k++) begin
          scan_idx = (int'(grant_reg) + k) % NUM_SRC;
          if (!found && s_axis_tvalid[scan_idx]) begin
            found      = 1'b1;
            grant_next = IDX_W'(scan_idx);
          end
        end
        if (found) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (accept && sel_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completed-packet counter, wraps naturally at its width.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_count_reg <= '0;
    end else if (accept && sel_last) begin
      pkt_count_reg <= pkt_count_reg + 1'b1;
    end
  end

  // Two-entry output buffer; order is preserved because the skid entry is
  // always older than anything still at the source.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      main_keep_reg  <= '0;
      main_last_reg  <= 1'b0;
      main_tid_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_keep_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_tid_reg   <= '0;
    end else begin
      if (skid_valid_reg) begin
        // Source is stalled while skid holds a beat; refill main from skid.
        if (m_axis_tready) begin
          main_data_reg  <= skid_data_reg;
          main_keep_reg  <= skid_keep_reg;
          main_last_reg  <= skid_last_reg;
          main_tid_reg   <= skid_tid_reg;
          skid_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid_reg || m_axis_tready) begin
          main_valid_reg <= 1'b1;
          main_data_reg  <= sel_data;
          main_keep_reg  <= sel_keep;
          main_last_reg  <= sel_last;
          main_tid_reg   <= grant_reg;
        end else begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= sel_data;
          skid_keep_reg  <= sel_keep;
          skid_last_reg  <= sel_last;
          skid_tid_reg   <= grant_reg;
        end
      end else if (m_axis_tready) begin
        main_valid_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = main_valid_reg;
  assign m_axis_tdata  = main_data_reg;
  assign m_axis_tkeep  = main_keep_reg;
  assign m_axis_tlast  = main_last_reg;
  assign m_axis_tid    = main_tid_reg;
  assign grant_idx     = grant_reg;
  assign busy          = (state_reg == XFER);
  assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: per-source beat tables, an output
// beat log, and hand-computed expected sequences.
module tb_axis_pkt_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0] s_axis_tkeep;
  logic [NS-1:0] s_axis_tlast;
  logic [NS-1:0] s_axis_tvalid;
  logic [NS-1:0] s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [0:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tid;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [1:0]    grant_idx;
  logic          busy;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Source beat tables: entry = {keep, last, data}
  logic [9:0] src_mem [NS][64];
  int         src_wr [NS];
  int         src_rd [NS];
  logic       pause  [NS];
  int         acc_cnt [NS];
  int         onehot_viol = 0;
  int         cyc = 0;

  // Output beat log
  logic [7:0] out_data [$];
  logic [1:0] out_tid  [$];
  logic       out_last [$];
  logic       out_keep [$];
  int         out_cyc  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("  ok   %s = 0x%0h", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (src_rd[i] != src_wr[i] && !pause[i]) begin
        s_axis_tvalid[i]          = 1'b1;
        s_axis_tdata[i*DW +: DW]  = src_mem[i][src_rd[i] % 64][7:0];
        s_axis_tlast[i]           = src_mem[i][src_rd[i] % 64][8];
        s_axis_tkeep[i]           = src_mem[i][src_rd[i] % 64][9];
      end else begin
        s_axis_tvalid[i]          = 1'b0;
        s_axis_tdata[i*DW +: DW]  = '0;
        s_axis_tlast[i]           = 1'b0;
        s_axis_tkeep[i]           = 1'b0;
      end
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l, input logic k);
    src_mem[s][src_wr[s] % 64] = {k, l, d};
    src_wr[s]++;
  endtask

  // Sample on the falling edge, advance stimulus just after the rising edge.
  task automatic tick();
    logic acc [NS];
    @(negedge clk);
    cyc++;
    if (m_axis_tvalid && m_axis_tready) begin
      out_data.push_back(m_axis_tdata);
      out_tid.push_back(m_axis_tid);
      out_last.push_back(m_axis_tlast);
      out_keep.push_back(m_axis_tkeep[0]);
      out_cyc.push_back(cyc);
      $display("  beat cyc=%0d tid=%0d data=0x%02h keep=%0d last=%0d",
               cyc, m_axis_tid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    if ($countones(s_axis_tready) > 1) onehot_viol++;
    for (int i = 0; i < NS; i++) begin
      acc[i] = s_axis_tvalid[i] && s_axis_tready[i];
      if (acc[i]) acc_cnt[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (acc[i]) src_rd[i]++;
    drive();
  endtask

  task automatic run_until(input int n, input string tag);
    int b = 0;
    while (out_data.size() < n && b < 300) begin
      tick();
      b++;
    end
    check(tag, out_data.size(), n);
  endtask

  task automatic clear_log();
    out_data.delete(); out_tid.delete(); out_last.delete();
    out_keep.delete(); out_cyc.delete();
  endtask

  initial begin
    logic [7:0] exp_d [9];
    logic [1:0] exp_t [9];
    int base;
    int b;

    areset        = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; pause[i] = 1'b0; acc_cnt[i] = 0;
    end
    drive();

    // ---- reset state ----
    tick(); tick();
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_grant", grant_idx, 3);
    check("rst_busy", busy, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tid", m_axis_tid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    areset = 1'b0;

    // ---- test 1: src0, two packets (0..4, 5..7), beat 3 has tkeep=0 ----
    for (int i = 0; i < 8; i++) push(0, 8'(i), (i == 4 || i == 7), (i != 3));
    drive();
    run_until(8, "t1_count");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_data%0d", i), out_data[i], i);
      check($sformatf("t1_last%0d", i), out_last[i], (i == 4 || i == 7));
      check($sformatf("t1_keep%0d", i), out_keep[i], (i != 3));
    end
    check("t1_tid_all0", {out_tid[0], out_tid[4], out_tid[5], out_tid[7]}, 0);
    check("t1_gap_in_pkt", out_cyc[1] - out_cyc[0], 1);
    check("t1_gap_between", out_cyc[5] - out_cyc[4], 2);
    tick(); tick();
    check("t1_pkt_count", pkt_count, 2);
    clear_log();

    // ---- test 2: src0, src1, src3 contend after a fresh reset ----
    areset = 1'b1; tick(); areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(0, 8'hA0 + 8'(i), (i == 2), 1'b1);
      push(1, 8'hB0 + 8'(i), (i == 2), 1'b1);
      push(3, 8'hD0 + 8'(i), (i == 2), 1'b1);
    end
    drive();
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hD0, 8'hD1, 8'hD2};
    exp_t = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    run_until(9, "t2_count");
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t2_data%0d", i), out_data[i], exp_d[i]);
      check($sformatf("t2_tid%0d", i), out_tid[i], exp_t[i]);
    end
    check("t2_last", {out_last[2], out_last[5], out_last[8], out_last[0], out_last[4]}, 5'b11100);
    tick(); tick();
    check("t2_grant", grant_idx, 3);
    check("t2_pkt_count", pkt_count, 3);
    clear_log();

    // ---- test 3: src2 four beats with downstream stalled ----
    m_axis_tready = 1'b0;
    base = acc_cnt[2];
    for (int i = 0; i < 4; i++) push(2, 8'hC0 + 8'(i), (i == 3), 1'b1);
    drive();
    b = 0;
    while (!m_axis_tvalid && b < 50) begin tick(); b++; end
    check("t3_first_valid", m_axis_tvalid, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t3_hold_data_c%0d", c), m_axis_tdata, 8'hC0);
    end
    check("t3_src_tready", s_axis_tready[2], 0);
    check("t3_accepted", acc_cnt[2] - base, 2);
    m_axis_tready = 1'b1;
    run_until(4, "t3_count");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_data%0d", i), out_data[i], 8'hC0 + 8'(i));
      check($sformatf("t3_tid%0d", i), out_tid[i], 2);
    end
    check("t3_last3", out_last[3], 1);
    tick(); tick();
    check("t3_pkt_count", pkt_count, 4);
    clear_log();

    // ---- test 4: src1 pauses mid-packet while src0 waits ----
    base = acc_cnt[1];
    for (int i = 0; i < 4; i++) push(1, 8'hE0 + 8'(i), (i == 3), 1'b1);
    drive();
    b = 0;
    while (acc_cnt[1] - base < 1 && b < 50) begin tick(); b++; end
    pause[1] = 1'b1;
    push(0, 8'hF0, 1'b0, 1'b1);
    push(0, 8'hF1, 1'b1, 1'b1);
    drive();
    base = acc_cnt[0];
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t4_grant_c%0d", c), grant_idx, 1);
      check($sformatf("t4_src0_rdy_c%0d", c), s_axis_tready[0], 0);
      check($sformatf("t4_busy_c%0d", c), busy, 1);
    end
    check("t4_src0_none", acc_cnt[0] - base, 0);
    pause[1] = 1'b0;
    drive();
    run_until(6, "t4_count");
    exp_d[0:5] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hF0, 8'hF1};
    exp_t[0:5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_data%0d", i), out_data[i], exp_d[i]);
      check($sformatf("t4_tid%0d", i), out_tid[i], exp_t[i]);
    end
    tick(); tick();
    check("t4_pkt_count", pkt_count, 6);
    clear_log();

    // ---- test 5: reset mid-packet with both buffer entries full ----
    m_axis_tready = 1'b0;
    base = acc_cnt[2];
    for (int i = 0; i < 4; i++) push(2, 8'h70 + 8'(i), (i == 3), 1'b1);
    drive();
    b = 0;
    while (acc_cnt[2] - base < 2 && b < 50) begin tick(); b++; end
    push(0, 8'h55, 1'b1, 1'b1);
    push(1, 8'h66, 1'b1, 1'b1);
    drive();
    #1;
    check("t5_pre_tvalid", m_axis_tvalid, 1);
    check("t5_pre_src_rdy", s_axis_tready[2], 0);
    areset = 1'b1;
    #1;
    check("t5_rst_tvalid", m_axis_tvalid, 0);
    check("t5_rst_tready", s_axis_tready, 0);
    check("t5_rst_pkt_count", pkt_count, 0);
    check("t5_rst_grant", grant_idx, 3);
    check("t5_rst_tlast", m_axis_tlast, 0);
    src_rd[2] = src_wr[2];
    drive();
    tick();
    areset = 1'b0;
    m_axis_tready = 1'b1;
    run_until(2, "t5_count");
    check("t5_first_tid", out_tid[0], 0);
    check("t5_first_data", out_data[0], 8'h55);
    check("t5_second_tid", out_tid[1], 1);
    check("t5_second_data", out_data[1], 8'h66);
    clear_log();

    // ---- test 6: 17 single-beat packets wrap the 4-bit counter ----
    areset = 1'b1; tick(); areset = 1'b0;
    for (int i = 0; i < 17; i++) push(0, 8'(i), 1'b1, 1'b1);
    drive();
    run_until(17, "t6_count");
    tick(); tick();
    check("t6_pkt_count_wrap", pkt_count, 1);
    check("t6_last_data", out_data[16], 16);

    check("tready_onehot", onehot_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
